// File: rtl/mem_io_responder.sv
// Bus target for memctrl: byte RAM, console TX/RX FIFOs, IO window at 0x30000 and halt latch.
// Optional IO_STATUS_REG_EN makes 0x30004 read back a status byte instead of 0x00.
module mem_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 8,
    parameter int RX_DEPTH   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        sim_halt
);
    localparam int TXW = $clog2(TX_DEPTH);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam int TXC = TXW + 1;
    localparam int RXC = RXW + 1;

    logic [7:0]     ram   [0:(2**ADDR_WIDTH)-1];
    logic [7:0]     txMem [0:TX_DEPTH-1];
    logic [7:0]     rxMem [0:RX_DEPTH-1];

    logic [TXW-1:0] txRd_q, txWr_q;
    logic [TXW:0]   txCnt_q, txCnt_d;
    logic [RXW-1:0] rxRd_q, rxWr_q;
    logic [RXW:0]   rxCnt_q, rxCnt_d;
    logic [7:0]     memDin_q, memDin_d;
    logic           simHalt_q, txOvf_q;

    logic           isIo, ioData, ioCtrl;
    logic           txFull, txPush, txPop, rxEmpty, rxPush, rxPop, ramWr;
    logic [7:0]     statusByte;
    logic           unusedBits;

    assign isIo   = (mem_a[17:16] == 2'b11);
    assign ioData = isIo && (mem_a[15:0] == 16'h0000);
    assign ioCtrl = isIo && (mem_a[15:0] == 16'h0004);

    assign txFull  = (txCnt_q == TXC'(TX_DEPTH));
    assign rxEmpty = (rxCnt_q == '0);
    assign ramWr   = rdy_in && mem_wr && !isIo;
    assign txPush  = rdy_in && mem_wr && ioData && !txFull;
    assign txPop   = rdy_in && tx_valid && tx_ready;
    assign rxPush  = rdy_in && rx_valid && rx_ready;
    assign rxPop   = rdy_in && !mem_wr && ioData && !rxEmpty;

`ifdef IO_STATUS_REG_EN
    assign statusByte = {4'b0000, txOvf_q, simHalt_q, !rxEmpty, txFull};
`else
    assign statusByte = 8'h00;
`endif

    assign unusedBits = ^{mem_a[31:18], txOvf_q};

    assign tx_valid       = (txCnt_q != '0);
    assign tx_data        = tx_valid ? txMem[txRd_q] : 8'h00;
    assign rx_ready       = (rxCnt_q != RXC'(RX_DEPTH));
    // Two-entry margin absorbs a store memctrl already issued before it saw the flag.
    assign io_buffer_full = (txCnt_q >= TXC'(TX_DEPTH - 2)) || simHalt_q;
    assign mem_din        = memDin_q;
    assign sim_halt       = simHalt_q;

    always_comb begin
        memDin_d = 8'h00;
        if (!mem_wr) begin
            if (!isIo) begin
                memDin_d = ram[mem_a[ADDR_WIDTH-1:0]];
            end else if (ioData) begin
                memDin_d = rxEmpty ? 8'h00 : rxMem[rxRd_q];
            end else if (ioCtrl) begin
                memDin_d = statusByte;
            end
        end
    end

    always_comb begin
        txCnt_d = txCnt_q;
        rxCnt_d = rxCnt_q;
        if (txPush && !txPop) begin
            txCnt_d = txCnt_q + 1'b1;
        end else if (!txPush && txPop) begin
            txCnt_d = txCnt_q - 1'b1;
        end
        if (rxPush && !rxPop) begin
            rxCnt_d = rxCnt_q + 1'b1;
        end else if (!rxPush && rxPop) begin
            rxCnt_d = rxCnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            txRd_q    <= '0;
            txWr_q    <= '0;
            txCnt_q   <= '0;
            rxRd_q    <= '0;
            rxWr_q    <= '0;
            rxCnt_q   <= '0;
            memDin_q  <= 8'h00;
            simHalt_q <= 1'b0;
            txOvf_q   <= 1'b0;
        end else if (rdy_in) begin
            memDin_q <= memDin_d;
            txCnt_q  <= txCnt_d;
            rxCnt_q  <= rxCnt_d;
            if (txPush) txWr_q <= txWr_q + 1'b1;
            if (txPop)  txRd_q <= txRd_q + 1'b1;
            if (rxPush) rxWr_q <= rxWr_q + 1'b1;
            if (rxPop)  rxRd_q <= rxRd_q + 1'b1;
            if (mem_wr && ioCtrl) simHalt_q <= 1'b1;
            if (mem_wr && ioData && txFull) txOvf_q <= 1'b1;
        end
    end

    // Storage arrays carry no reset so RAM contents survive rst_in.
    always_ff @(posedge clk_in) begin
        if (ramWr)  ram[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
        if (txPush) txMem[txWr_q] <= mem_dout;
        if (rxPush) rxMem[rxWr_q] <= rx_data;
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Randomised bench for mem_io_responder checked against a queue-based reference model.
module tb_mem_io_responder;
    localparam int TXD = 8;
    localparam int RXD = 8;

    logic        clk = 1'b0, rst = 1'b1, rdy = 1'b0;
    logic [31:0] memA = 32'h0;
    logic        memWr = 1'b0, txReady = 1'b0, rxValid = 1'b0;
    logic [7:0]  memDout = 8'h0, rxData = 8'h0;
    logic [7:0]  memDin, txData;
    logic        ioBufferFull, txValid, rxReady, simHalt;

    mem_io_responder dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .mem_a(memA), .mem_wr(memWr),
        .mem_dout(memDout), .mem_din(memDin), .io_buffer_full(ioBufferFull),
        .tx_data(txData), .tx_valid(txValid), .tx_ready(txReady),
        .rx_data(rxData), .rx_valid(rxValid), .rx_ready(rxReady), .sim_halt(simHalt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] txQ[$];
    logic [7:0] rxQ[$];
    logic [7:0] ramModel[int];
    logic       haltM, ovfM, dinKnown;
    logic [7:0] dinM;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        txQ.delete();
        rxQ.delete();
        haltM = 1'b0;
        ovfM = 1'b0;
        dinM = 8'h00;
        dinKnown = 1'b1;
    endtask

    task automatic checkAll();
        checkOutput("tx_valid", 32'(txValid), 32'(txQ.size() != 0));
        checkOutput("tx_data", 32'(txData), (txQ.size() != 0) ? 32'(txQ[0]) : 32'h0);
        checkOutput("rx_ready", 32'(rxReady), 32'(rxQ.size() < RXD));
        checkOutput("io_buffer_full", 32'(ioBufferFull), 32'((txQ.size() >= TXD - 2) || haltM));
        checkOutput("sim_halt", 32'(simHalt), 32'(haltM));
        if (dinKnown) checkOutput("mem_din", 32'(memDin), 32'(dinM));
    endtask

    // Applies one bus cycle of the model using the pre-edge queue contents.
    task automatic modelStep();
        logic [17:0] a;
        logic        io, txPop, txWasFull, rxHostPush, pushTx;
        logic [7:0]  status;
        int          idx;
        if (!rdy) return;
        a = memA[17:0];
        io = (a[17:16] == 2'b11);
        idx = int'(a[16:0]);
        txPop = (txQ.size() > 0) && txReady;
        txWasFull = (txQ.size() == TXD);
        rxHostPush = rxValid && (rxQ.size() < RXD);
        pushTx = 1'b0;
`ifdef IO_STATUS_REG_EN
        status = {4'b0000, ovfM, haltM, rxQ.size() != 0, txWasFull};
`else
        status = 8'h00;
`endif
        dinM = 8'h00;
        dinKnown = 1'b1;
        if (memWr) begin
            if (!io) ramModel[idx] = memDout;
            else if (a == 18'h30000) begin
                if (txWasFull) ovfM = 1'b1;
                else pushTx = 1'b1;
            end else if (a == 18'h30004) haltM = 1'b1;
        end else begin
            if (!io) begin
                if (ramModel.exists(idx)) dinM = ramModel[idx];
                else dinKnown = 1'b0;
            end else if (a == 18'h30000) begin
                if (rxQ.size() > 0) dinM = rxQ.pop_front();
            end else if (a == 18'h30004) dinM = status;
        end
        if (txPop) void'(txQ.pop_front());
        if (pushTx) txQ.push_back(memDout);
        if (rxHostPush) rxQ.push_back(rxData);
    endtask

    task automatic applyStimulus(input logic r, input logic [31:0] a, input logic w,
                                 input logic [7:0] d, input logic txr,
                                 input logic [7:0] rxd, input logic rxv);
        rdy = r; memA = a; memWr = w; memDout = d;
        txReady = txr; rxData = rxd; rxValid = rxv;
        #1;
        checkAll();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic        w;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        checkAll();
        rst = 1'b0;

        // RAM write/read with a neighbouring byte
        applyStimulus(1, 32'h0000_00FF, 1, 8'h3C, 0, 8'h00, 0);
        applyStimulus(1, 32'h0000_0100, 1, 8'hA5, 0, 8'h00, 0);
        applyStimulus(1, 32'hFFFC_0100, 0, 8'h00, 0, 8'h00, 0);
        applyStimulus(1, 32'h0000_00FF, 0, 8'h00, 0, 8'h00, 0);

        // TX backpressure: 14 stores with the sink stalled, then drain
        for (int i = 0; i < 14; i++)
            applyStimulus(1, 32'h0003_0000, 1, 8'(8'h10 + i), 0, 8'h00, 0);
`ifdef IO_STATUS_REG_EN
        applyStimulus(1, 32'h0003_0004, 0, 8'h00, 0, 8'h00, 0);
`endif
        for (int i = 0; i < 10; i++)
            applyStimulus(1, 32'h0003_0008, 0, 8'h00, 1, 8'h00, 0);

        // RX: two host bytes, three bus reads, then simultaneous push and pop
        applyStimulus(1, 32'h0003_0008, 0, 8'h00, 0, 8'h41, 1);
        applyStimulus(1, 32'h0003_0008, 0, 8'h00, 0, 8'h42, 1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 32'h0003_0000, 0, 8'h00, 0, 8'h00, 0);
        applyStimulus(1, 32'h0003_0008, 0, 8'h00, 0, 8'h51, 1);
        applyStimulus(1, 32'h0003_0000, 0, 8'h00, 0, 8'h52, 1);
        applyStimulus(1, 32'h0003_0000, 0, 8'h00, 0, 8'h00, 0);
        applyStimulus(1, 32'h0003_0000, 0, 8'h00, 0, 8'h00, 0);

        // Frozen store held across rdy_in=0 must push once
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 32'h0003_0000, 1, 8'h77, 1, 8'h99, 1);
        applyStimulus(1, 32'h0003_0000, 1, 8'h77, 0, 8'h00, 0);
        applyStimulus(1, 32'h0003_0008, 0, 8'h00, 0, 8'h00, 0);
        applyStimulus(1, 32'h0003_0008, 0, 8'h00, 1, 8'h00, 0);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            a = $urandom();
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: a[16:0] = 17'h00100 + 17'($urandom_range(0, 15));
                5, 6:          a[17:0] = 18'h30000;
                7:             begin a[17:0] = 18'h30004; w = 1'b0; end
                default:       a[17:0] = 18'h30000 + 18'(4 * $urandom_range(2, 15));
            endcase
            applyStimulus(1'($urandom_range(0, 99) < 85), a, w, 8'($urandom()),
                          1'($urandom_range(0, 1)), 8'($urandom()), 1'($urandom_range(0, 1)));
        end

        // Halt, status read, then reset with both FIFOs populated
        applyStimulus(1, 32'h0000_0100, 1, 8'hA5, 0, 8'h00, 0);
        applyStimulus(1, 32'h0003_0000, 1, 8'hC1, 0, 8'h61, 1);
        applyStimulus(1, 32'h0003_0004, 1, 8'h5A, 0, 8'h62, 1);
        applyStimulus(1, 32'h0003_0004, 0, 8'h00, 0, 8'h00, 0);
        applyStimulus(1, 32'h0003_0008, 0, 8'h00, 0, 8'h00, 0);
        rdy = 1'b1; memA = 32'h0003_0008; memWr = 1'b0; txReady = 1'b0; rxValid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        resetModel();
        checkAll();
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1, 32'h0000_0100, 0, 8'h00, 0, 8'h00, 0);
        applyStimulus(1, 32'h0003_0008, 0, 8'h00, 0, 8'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
